// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-ported memory.
// Latency: grant in the request cycle, response LAT+1 cycles after grant.
// Backpressure: requesters hold until gnt; one transaction in flight at a time.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1   // memory read latency, 1..4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT_C = 3'(LAT);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic          r_last_owner;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  logic          w_grant;
  logic          w_pick_dm;
  logic          w_capture;

  // Arbitration: grant only while idle and out of reset; on contention the
  // port that did not win last time goes first.
  always_comb begin
    w_grant   = (r_state == S_IDLE) && !rst && (if_req || dm_req);
    w_pick_dm = dm_req && (!if_req || (r_last_owner == OWN_IF));
    w_capture = (r_state == S_WAIT) && (r_cnt == LAT_C);
  end

  // Port and memory outputs; memory address/data hold their last value
  // outside the grant cycle so the memory sees a stable bus.
  always_comb begin
    if_gnt    = w_grant && !w_pick_dm;
    dm_gnt    = w_grant && w_pick_dm;
    mem_en    = w_grant;
    mem_we    = w_grant && w_pick_dm && dm_we;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    if (w_grant) begin
      mem_addr = w_pick_dm ? dm_addr : if_addr;
      if (w_pick_dm) mem_wdata = dm_wdata;
    end
    if_rvalid = (r_state == S_RESP) && (r_owner == OWN_IF);
    dm_rvalid = (r_state == S_RESP) && (r_owner == OWN_DM);
    if_rdata  = r_if_rdata;
    dm_rdata  = r_dm_rdata;
  end

  // FSM state and latency counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state: grant -> count latency -> one response cycle -> idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 3'd1;
        end
      end
      S_WAIT: begin
        if (w_capture) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 3'd1;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Latch the transaction at grant and capture read data when latency expires;
  // a store acknowledge returns zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= OWN_IF;
      r_owner      <= OWN_IF;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_last_owner <= w_pick_dm;
        r_owner      <= w_pick_dm;
        r_we         <= w_pick_dm && dm_we;
        r_mem_addr   <= mem_addr;
        r_mem_wdata  <= mem_wdata;
      end
      if (w_capture) begin
        if (r_owner == OWN_IF) r_if_rdata <= mem_rdata;
        else                   r_dm_rdata <= r_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (LAT=1,2,4) share inputs.
// Each directed step drives inputs just after a rising edge, checks outputs 2ns later.
// Expected values are hand-derived from the cycle-level timing of the arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic        if_gnt[3], if_rvalid[3], dm_gnt[3], dm_rvalid[3], mem_en[3], mem_we[3];
  logic [31:0] if_rdata[3], dm_rdata[3], mem_addr[3], mem_wdata[3];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic exp_dm, exp_if;

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]), .dm_rdata(dm_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(2)) u_l2 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]), .dm_rdata(dm_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(4)) u_l4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[2]),
    .if_rvalid(if_rvalid[2]), .if_rdata(if_rdata[2]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt[2]), .dm_rvalid(dm_rvalid[2]), .dm_rdata(dm_rdata[2]),
    .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]),
    .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    tick; tick;

    // Reset state, with both ports requesting: nothing may be granted.
    if_req = 1'b1; dm_req = 1'b1; settle;
    chk1("rst_if_gnt",    if_gnt[0],    1'b0);
    chk1("rst_dm_gnt",    dm_gnt[0],    1'b0);
    chk1("rst_mem_en",    mem_en[0],    1'b0);
    chk1("rst_mem_we",    mem_we[0],    1'b0);
    chk ("rst_mem_addr",  mem_addr[0],  32'h0);
    chk ("rst_mem_wdata", mem_wdata[0], 32'h0);
    chk ("rst_if_rdata",  if_rdata[0],  32'h0);
    chk ("rst_dm_rdata",  dm_rdata[0],  32'h0);
    chk1("rst_if_rvalid", if_rvalid[0], 1'b0);
    chk1("rst_dm_rvalid", dm_rvalid[0], 1'b0);

    // LAT=1 fetch of 0x100, memory returns 0xDEADBEEF at T+1.
    tick; rst = 1'b0; dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h100; settle;
    chk1("f_T_if_gnt",   if_gnt[0],   1'b1);
    chk1("f_T_dm_gnt",   dm_gnt[0],   1'b0);
    chk1("f_T_mem_en",   mem_en[0],   1'b1);
    chk1("f_T_mem_we",   mem_we[0],   1'b0);
    chk ("f_T_mem_addr", mem_addr[0], 32'h100);
    tick; if_req = 1'b0; mem_rdata = 32'hDEADBEEF; settle;
    chk1("f_T1_if_gnt",   if_gnt[0],    1'b0);
    chk1("f_T1_mem_en",   mem_en[0],    1'b0);
    chk ("f_T1_mem_addr", mem_addr[0],  32'h100);
    chk1("f_T1_if_rvalid", if_rvalid[0], 1'b0);
    tick; mem_rdata = 32'hBAD0BAD0; settle;
    chk1("f_T2_if_rvalid", if_rvalid[0], 1'b1);
    chk ("f_T2_if_rdata",  if_rdata[0],  32'hDEADBEEF);
    chk1("f_T2_dm_rvalid", dm_rvalid[0], 1'b0);

    // T+3 must be IDLE again: a store is granted immediately.
    tick; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678; settle;
    chk1("f_T3_if_rvalid", if_rvalid[0], 1'b0);
    chk1("st_T_dm_gnt",    dm_gnt[0],    1'b1);
    chk1("st_T_if_gnt",    if_gnt[0],    1'b0);
    chk1("st_T_mem_we",    mem_we[0],    1'b1);
    chk ("st_T_mem_addr",  mem_addr[0],  32'h40);
    chk ("st_T_mem_wdata", mem_wdata[0], 32'h12345678);
    tick; dm_req = 1'b0; dm_addr = 32'h80; dm_wdata = 32'h0; mem_rdata = 32'h55AA55AA; settle;
    chk1("st_T1_mem_we",    mem_we[0],    1'b0);
    chk1("st_T1_mem_en",    mem_en[0],    1'b0);
    chk ("st_T1_mem_wdata", mem_wdata[0], 32'h12345678);
    tick; settle;
    chk1("st_T2_dm_rvalid", dm_rvalid[0], 1'b1);
    chk ("st_T2_dm_rdata",  dm_rdata[0],  32'h0);
    chk ("st_T2_if_rdata",  if_rdata[0],  32'hDEADBEEF);
    tick; settle;
    chk1("st_T3_dm_rvalid", dm_rvalid[0], 1'b0);

    // Load from 0x40, address changed to 0x80 right after grant and held
    // as a new pending request.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; settle;
    chk1("ld_T_dm_gnt",   dm_gnt[0],   1'b1);
    chk ("ld_T_mem_addr", mem_addr[0], 32'h40);
    tick; dm_addr = 32'h80; mem_rdata = 32'h40404040; settle;
    chk1("ld_T1_dm_gnt",   dm_gnt[0],   1'b0);
    chk ("ld_T1_mem_addr", mem_addr[0], 32'h40);
    tick; mem_rdata = 32'hBAD0BAD0; settle;
    chk1("ld_T2_dm_rvalid", dm_rvalid[0], 1'b1);
    chk ("ld_T2_dm_rdata",  dm_rdata[0],  32'h40404040);
    chk1("ld_T2_dm_gnt",    dm_gnt[0],    1'b0);
    tick; settle;
    chk1("ld_T3_dm_gnt",    dm_gnt[0],    1'b1);
    chk ("ld_T3_mem_addr",  mem_addr[0],  32'h80);
    chk1("ld_T3_dm_rvalid", dm_rvalid[0], 1'b0);

    // LAT=2, both ports requesting continuously: dm, if, dm ... every 4 cycles.
    tick; rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; settle;
    tick; rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h200; dm_addr = 32'h300; settle;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin tick; settle; end
      exp_dm = ((c % 4) == 0) && (((c / 4) % 2) == 0);
      exp_if = ((c % 4) == 0) && (((c / 4) % 2) == 1);
      chk1($sformatf("rr_c%0d_dm_gnt", c), dm_gnt[1], exp_dm);
      chk1($sformatf("rr_c%0d_if_gnt", c), if_gnt[1], exp_if);
      if (exp_dm) chk($sformatf("rr_c%0d_mem_addr", c), mem_addr[1], 32'h300);
      if (exp_if) chk($sformatf("rr_c%0d_mem_addr", c), mem_addr[1], 32'h200);
    end

    // LAT=4: reset in WAIT aborts the fetch; the pending fetch is then
    // granted on the first IDLE cycle.
    tick; rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; settle;
    tick; rst = 1'b0; if_req = 1'b1; if_addr = 32'h500; settle;
    chk1("ab_T_if_gnt",   if_gnt[2],   1'b1);
    chk ("ab_T_mem_addr", mem_addr[2], 32'h500);
    tick; if_req = 1'b0; settle;
    tick; settle;
    chk1("ab_T2_if_gnt", if_gnt[2], 1'b0);
    rst = 1'b1; if_req = 1'b1; settle;
    chk1("ab_rst_if_gnt",    if_gnt[2],    1'b0);
    chk1("ab_rst_mem_en",    mem_en[2],    1'b0);
    chk ("ab_rst_mem_addr",  mem_addr[2],  32'h0);
    chk1("ab_rst_if_rvalid", if_rvalid[2], 1'b0);
    chk ("ab_rst_if_rdata",  if_rdata[2],  32'h0);
    tick; rst = 1'b0; settle;
    chk1("ab_G_if_gnt", if_gnt[2], 1'b1);
    chk1("ab_G_mem_en", mem_en[2], 1'b1);

    // From grant G: fetch dropped at G+1, raised again at G+2 during WAIT.
    // rvalid only at G+5, next grant exactly at G+6.
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c == 1) if_req = 1'b0;
      if (c == 2) if_req = 1'b1;
      mem_rdata = (c == 4) ? 32'h44444444 : 32'hBAD0BAD0;
      settle;
      chk1($sformatf("l4_G%0d_if_gnt", c),    if_gnt[2],    c == 6);
      chk1($sformatf("l4_G%0d_if_rvalid", c), if_rvalid[2], c == 5);
      if (c == 5) chk("l4_G5_if_rdata", if_rdata[2], 32'h44444444);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
